// File: rtl/arb_request_mux.sv
`timescale 1ns/1ps
// arb_request_mux
// Holds one pending payload per client, presents the pending set as a request
// vector to an external combinational arbiter, and moves the granted payload
// into a single registered valid/ready output stage. A malformed grant raises
// a sticky error flag and is otherwise ignored.
module arb_request_mux #(
    parameter int REQ_WIDTH  = 8,
    parameter int DATA_WIDTH = 32,
    parameter int SRC_WIDTH  = $clog2(REQ_WIDTH)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [REQ_WIDTH-1:0]            in_valid,
    output logic [REQ_WIDTH-1:0]            in_ready,
    input  logic [REQ_WIDTH*DATA_WIDTH-1:0] in_data,
    output logic [REQ_WIDTH-1:0]            req,
    input  logic [REQ_WIDTH-1:0]            gnt,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [DATA_WIDTH-1:0]           out_data,
    output logic [SRC_WIDTH-1:0]            out_src,
    output logic                            err
);

    logic [REQ_WIDTH-1:0]  full_q, full_d;
    logic [DATA_WIDTH-1:0] slotData_q [REQ_WIDTH];
    logic                  outValid_q, outValid_d;
    logic [DATA_WIDTH-1:0] outData_q, outData_d;
    logic [SRC_WIDTH-1:0]  outSrc_q, outSrc_d;
    logic                  err_q, err_d;

    logic                  canLoad;
    logic                  gntMulti;
    logic                  gntStray;
    logic                  gntBad;
    logic                  captureEn;
    logic [REQ_WIDTH-1:0]  captureVec;
    logic [REQ_WIDTH-1:0]  loadEn;
    logic [SRC_WIDTH-1:0]  gntIdx;

    // The output stage can accept a new payload when empty or draining this cycle.
    // Requests are masked while stalled so the arbiter only rotates on real consumption.
    assign canLoad    = !outValid_q || out_ready;
    assign req        = full_q & {REQ_WIDTH{canLoad}};
    assign in_ready   = ~full_q;

    // A grant is usable only if it is one-hot and lands on a bit we are requesting.
    assign gntMulti   = |(gnt & (gnt - REQ_WIDTH'(1)));
    assign gntStray   = |(gnt & ~req);
    assign gntBad     = gntMulti | gntStray;
    assign captureEn  = canLoad && (gnt != '0) && !gntBad;
    assign captureVec = captureEn ? gnt : '0;
    assign loadEn     = in_valid & ~full_q;

    // Convert the one-hot grant into a client index.
    always_comb begin
        gntIdx = '0;
        for (int i = 0; i < REQ_WIDTH; i++) begin
            if (gnt[i]) begin
                gntIdx = SRC_WIDTH'(i);
            end
        end
    end

    // Next-state for slot occupancy, the output stage and the sticky error flag.
    always_comb begin
        full_d     = (full_q | loadEn) & ~captureVec;
        outValid_d = outValid_q;
        outData_d  = outData_q;
        outSrc_d   = outSrc_q;
        err_d      = err_q | gntBad;
        if (captureEn) begin
            outValid_d = 1'b1;
            outData_d  = slotData_q[gntIdx];
            outSrc_d   = gntIdx;
        end else if (out_ready) begin
            outValid_d = 1'b0;
        end
    end

    // Control and output registers; reset discards every pending payload at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q     <= '0;
            outValid_q <= 1'b0;
            outData_q  <= '0;
            outSrc_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            full_q     <= full_d;
            outValid_q <= outValid_d;
            outData_q  <= outData_d;
            outSrc_q   <= outSrc_d;
            err_q      <= err_d;
        end
    end

    // Per-client payload capture whenever an empty slot sees valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REQ_WIDTH; i++) begin
                slotData_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < REQ_WIDTH; i++) begin
                if (loadEn[i]) begin
                    slotData_q[i] <= in_data[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    assign out_valid = outValid_q;
    assign out_data  = outData_q;
    assign out_src   = outSrc_q;
    assign err       = err_q;

endmodule

// File: tb/tb_arb_request_mux.sv
`timescale 1ns/1ps
// Bench for arb_request_mux with a round-robin arbiter model (base bit 0)
// and an override mode that drives arbitrary grant patterns.
module tb_arb_request_mux;

    localparam int N  = 8;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  inValid = '0;
    logic [N-1:0]  inReady;
    logic [N*DW-1:0] inData = '0;
    logic [N-1:0]  req;
    logic [N-1:0]  gnt;
    logic          outValid;
    logic          outReady = 1'b1;
    logic [DW-1:0] outData;
    logic [2:0]    outSrc;
    logic          err;

    logic          forceMode = 1'b0;
    logic [N-1:0]  forcedGnt = '0;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    logic [DW+2:0] sbQ [$];

    arb_request_mux #(.REQ_WIDTH(N), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .in_data   (inData),
        .req       (req),
        .gnt       (gnt),
        .out_valid (outValid),
        .out_ready (outReady),
        .out_data  (outData),
        .out_src   (outSrc),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Round-robin arbiter model: highest priority at rrPtr, moves past each grant.
    logic [2:0]   rrPtr;
    logic [2:0]   arbIdx;
    logic [2:0]   scanIdx;
    logic         arbFound;
    logic [N-1:0] arbGnt;

    always_comb begin
        arbGnt   = '0;
        arbIdx   = '0;
        arbFound = 1'b0;
        scanIdx  = '0;
        for (int j = 0; j < N; j++) begin
            scanIdx = rrPtr + 3'(j);
            if (!arbFound && req[scanIdx]) begin
                arbGnt[scanIdx] = 1'b1;
                arbIdx          = scanIdx;
                arbFound        = 1'b1;
            end
        end
    end

    assign gnt = forceMode ? forcedGnt : arbGnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rrPtr <= '0;
        end else if (!forceMode && arbFound) begin
            rrPtr <= arbIdx + 3'd1;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] valid);
        @(posedge clk);
        #1;
        inValid = valid;
    endtask

    task automatic setData(input int client, input logic [DW-1:0] value);
        inData[client*DW +: DW] = value;
    endtask

    task automatic sbPush(input logic [DW-1:0] data, input logic [2:0] src);
        sbQ.push_back({data, src});
    endtask

    task automatic doReset();
        rst_n     = 1'b0;
        inValid   = '0;
        outReady  = 1'b1;
        forcedGnt = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        sbQ.delete();
    endtask

    task automatic waitDrain(input string tag);
        for (int c = 0; c < 60 && sbQ.size() != 0; c++) begin
            @(negedge clk);
        end
        checkOutput(tag, 64'(sbQ.size()), 64'd0);
    endtask

    // Scoreboard monitor: every consumed output must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && outValid && outReady) begin
            checkCount++;
            assert (sbQ.size() != 0) passCount++;
            else begin
                failCount++;
                $error("[TB] FAIL unexpectedOutput: observed data %0h src %0d expected none", outData, outSrc);
            end
            if (sbQ.size() != 0) begin
                logic [DW+2:0] exp;
                exp = sbQ.pop_front();
                checkOutput("outData", 64'(outData), 64'(exp[DW+2:3]));
                checkOutput("outSrc", 64'(outSrc), 64'(exp[2:0]));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [8:0]    mask;
        logic [DW-1:0] streamData;

        // Reset state
        doReset();
        checkOutput("rstInReady", 64'(inReady), 64'hFF);
        checkOutput("rstReq", 64'(req), 64'h00);
        checkOutput("rstOutValid", 64'(outValid), 64'd0);
        checkOutput("rstOutData", 64'(outData), 64'd0);
        checkOutput("rstOutSrc", 64'(outSrc), 64'd0);
        checkOutput("rstErr", 64'(err), 64'd0);

        // Single client, two-cycle latency
        setData(3, 32'hA5A5_0003);
        applyStimulus(8'h08);
        sbPush(32'hA5A5_0003, 3'd3);
        applyStimulus(8'h00);
        @(negedge clk);
        checkOutput("s1InReadyT1", 64'(inReady), 64'hF7);
        checkOutput("s1ReqT1", 64'(req), 64'h08);
        checkOutput("s1OutValidT1", 64'(outValid), 64'd0);
        @(negedge clk);
        checkOutput("s1OutValidT2", 64'(outValid), 64'd1);
        checkOutput("s1InReadyT2", 64'(inReady), 64'hFF);
        checkOutput("s1Err", 64'(err), 64'd0);
        waitDrain("s1Drain");

        // All clients full, round-robin order 0..7
        doReset();
        for (int i = 0; i < N; i++) begin
            setData(i, 32'h100 + 32'(i));
        end
        applyStimulus(8'hFF);
        for (int i = 0; i < N; i++) begin
            sbPush(32'h100 + 32'(i), 3'(i));
        end
        applyStimulus(8'h00);
        for (int k = 0; k <= N; k++) begin
            @(negedge clk);
            mask = (9'd1 << k) - 9'd1;
            checkOutput($sformatf("s2InReady%0d", k), 64'(inReady), 64'(mask[7:0]));
            checkOutput($sformatf("s2OutValid%0d", k), 64'(outValid), (k == 0) ? 64'd0 : 64'd1);
        end
        waitDrain("s2Drain");

        // Backpressure: output held, requests masked
        doReset();
        setData(1, 32'hB000_0001);
        setData(2, 32'hB000_0002);
        applyStimulus(8'h06);
        sbPush(32'hB000_0001, 3'd1);
        sbPush(32'hB000_0002, 3'd2);
        applyStimulus(8'h00);
        @(posedge clk);
        #1;
        outReady = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput("s3StallReq", 64'(req), 64'h00);
            checkOutput("s3StallValid", 64'(outValid), 64'd1);
            checkOutput("s3StallData", 64'(outData), 64'hB000_0001);
            checkOutput("s3StallSrc", 64'(outSrc), 64'd1);
            checkOutput("s3StallInReady", 64'(inReady), 64'hFB);
        end
        @(posedge clk);
        #1;
        outReady = 1'b1;
        @(negedge clk);
        checkOutput("s3ReleaseReq", 64'(req), 64'h04);
        @(negedge clk);
        checkOutput("s3NextValid", 64'(outValid), 64'd1);
        checkOutput("s3NextSrc", 64'(outSrc), 64'd2);
        waitDrain("s3Drain");
        @(negedge clk);
        checkOutput("s3IdleValid", 64'(outValid), 64'd0);

        // Streaming from client 0: accepted every other cycle
        doReset();
        streamData = 32'hC000_0000;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            inValid = 8'h01;
            setData(0, streamData);
            @(negedge clk);
            checkOutput($sformatf("s4InReady%0d", i), 64'(inReady[0]), (i % 2 == 0) ? 64'd1 : 64'd0);
            if (i % 2 == 0) begin
                sbPush(streamData, 3'd0);
                streamData = streamData + 32'd1;
            end
        end
        applyStimulus(8'h00);
        waitDrain("s4Drain");

        // Multi-hot grant
        forceMode = 1'b1;
        doReset();
        setData(0, 32'hD000_0000);
        setData(1, 32'hD000_0001);
        applyStimulus(8'h03);
        applyStimulus(8'h00);
        forcedGnt = 8'h03;
        @(negedge clk);
        checkOutput("s5aReq", 64'(req), 64'h03);
        checkOutput("s5aErrBefore", 64'(err), 64'd0);
        @(posedge clk);
        #1;
        forcedGnt = 8'h00;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("s5aErr", 64'(err), 64'd1);
            checkOutput("s5aInReady", 64'(inReady), 64'hFC);
            checkOutput("s5aOutValid", 64'(outValid), 64'd0);
        end

        // Grant on an empty slot
        doReset();
        checkOutput("s5bErrCleared", 64'(err), 64'd0);
        @(posedge clk);
        #1;
        forcedGnt = 8'h04;
        @(posedge clk);
        #1;
        forcedGnt = 8'h00;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput("s5bErr", 64'(err), 64'd1);
            checkOutput("s5bInReady", 64'(inReady), 64'hFF);
            checkOutput("s5bOutValid", 64'(outValid), 64'd0);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("s5bErrReset", 64'(err), 64'd0);
        forceMode = 1'b0;

        // Asynchronous reset while payloads are in flight
        doReset();
        for (int i = 0; i < 4; i++) begin
            setData(i, 32'hE000_0000 + 32'(i));
        end
        applyStimulus(8'h0F);
        outReady = 1'b0;
        applyStimulus(8'h00);
        @(negedge clk);
        @(negedge clk);
        checkOutput("s6PreValid", 64'(outValid), 64'd1);
        checkOutput("s6PreInReady", 64'(inReady), 64'hF1);
        checkOutput("s6PreSrc", 64'(outSrc), 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("s6RstValid", 64'(outValid), 64'd0);
        checkOutput("s6RstReq", 64'(req), 64'h00);
        checkOutput("s6RstInReady", 64'(inReady), 64'hFF);
        checkOutput("s6RstData", 64'(outData), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        outReady = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput("s6PostValid", 64'(outValid), 64'd0);
            checkOutput("s6PostReq", 64'(req), 64'h00);
            checkOutput("s6PostInReady", 64'(inReady), 64'hFF);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
